// File: rtl/safe_pkg.sv
// Shared types and dial helpers for the strong-box access sequencer.
package safe_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_t;

  function automatic logic [DIGIT_W-1:0] onehot_to_bcd(input logic [9:0] oh);
    logic [DIGIT_W-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (oh[i]) d = DIGIT_W'(i);
    end
    return d;
  endfunction

  function automatic logic [DIGIT_W-1:0] mod10_inc(input logic [DIGIT_W-1:0] d);
    return (d == DIGIT_W'(9)) ? '0 : d + 1'b1;
  endfunction

  function automatic logic [DIGIT_W-1:0] mod10_dec(input logic [DIGIT_W-1:0] d);
    return (d == '0) ? DIGIT_W'(9) : d - 1'b1;
  endfunction

endpackage

// File: rtl/safe_access_ctrl_dial_tracker.sv
// Dial position tracker: validates one-hot samples, detects +/-1 steps and
// emits a capture strobe at each direction reversal plus a jump error strobe.
module dial_tracker
  import safe_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         keypad,
  input  logic               clear,
  input  logic               arm,
  output logic [DIGIT_W-1:0] pos_now,
  output logic               step,
  output logic               cap_stb,
  output logic [DIGIT_W-1:0] cap_digit,
  output logic               err_stb
);

  logic [DIGIT_W-1:0] pos_q, samp;
  dir_t               dir_q, dir_n;
  logic               valid, up, dn, jump;

  always_comb begin
    valid     = $onehot(keypad);
    samp      = onehot_to_bcd(keypad);
    up        = valid && (samp == mod10_inc(pos_q));
    dn        = valid && (samp == mod10_dec(pos_q));
    jump      = valid && (samp != pos_q) && !up && !dn;
    pos_now   = valid ? samp : pos_q;
    step      = up || dn;
    cap_digit = pos_q;
    cap_stb   = arm && ((up && dir_q == DIR_DN) || (dn && dir_q == DIR_UP));
    err_stb   = arm && jump;
    dir_n     = dir_q;
    if (clear || jump) dir_n = DIR_NONE;
    else if (up)       dir_n = DIR_UP;
    else if (dn)       dir_n = DIR_DN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
      dir_q <= DIR_NONE;
    end else begin
      pos_q <= pos_now;
      dir_q <= dir_n;
    end
  end

endmodule

// File: rtl/safe_access_ctrl.sv
// Strong-box access sequencer: combination entry, check, open hold, failure
// counting and lockout. SAFE_PROGRESSIVE_LOCKOUT_EN doubles each lockout.
module safe_access_ctrl
  import safe_pkg::*;
#(
  parameter int DIGITS       = 6,
  parameter int MAX_FAIL     = 3,
  parameter int OPEN_CYC     = 500,
  parameter int LOCKOUT_CYC  = 1000,
  parameter int ENTRY_TO_CYC = 2000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIGIT_W*DIGITS-1:0] code,
  input  logic [9:0]                keypad,
  input  logic                      tryopen,
  output logic                      lock_open,
  output logic                      locked_out,
  output logic [1:0]                fail_cnt,
  output logic [2:0]                state_o
);

  localparam int NCW = $clog2(DIGITS + 1);
  localparam int TW  = $clog2(LOCKOUT_CYC * 8 + OPEN_CYC + ENTRY_TO_CYC + 1);

  state_t                          state_q, state_n;
  logic                            try_q, try_edge;
  logic [DIGITS-1:0][DIGIT_W-1:0]  digits_q, digits_n;
  logic [NCW-1:0]                  ncap_q, ncap_n;
  logic                            err_q, err_n;
  logic [TW-1:0]                   tmr_q, tmr_n, lock_dur;
  logic [1:0]                      fail_q, fail_n;
  logic [DIGIT_W-1:0]              trk_pos, trk_digit;
  logic                            trk_step, trk_cap, trk_err;
`ifdef SAFE_PROGRESSIVE_LOCKOUT_EN
  logic [1:0]                      lvl_q, lvl_n;
`endif

  assign try_edge = tryopen && !try_q;
  assign fail_cnt = fail_q;
  assign state_o  = state_q;

  dial_tracker u_dial (
    .clk       (clk),
    .rst       (rst),
    .keypad    (keypad),
    .clear     (state_q == S_IDLE && try_edge),
    .arm       (state_q == S_ENTRY),
    .pos_now   (trk_pos),
    .step      (trk_step),
    .cap_stb   (trk_cap),
    .cap_digit (trk_digit),
    .err_stb   (trk_err)
  );

  always_comb begin
    state_n  = state_q;
    digits_n = digits_q;
    ncap_n   = ncap_q;
    err_n    = err_q;
    tmr_n    = tmr_q;
    fail_n   = fail_q;
`ifdef SAFE_PROGRESSIVE_LOCKOUT_EN
    lvl_n    = lvl_q;
    lock_dur = TW'(LOCKOUT_CYC) << lvl_q;
`else
    lock_dur = TW'(LOCKOUT_CYC);
`endif
    case (state_q)
      S_IDLE: begin
        if (try_edge) begin
          state_n  = S_ENTRY;
          digits_n = '0;
          ncap_n   = '0;
          err_n    = 1'b0;
          tmr_n    = TW'(ENTRY_TO_CYC - 1);
        end
      end
      S_ENTRY: begin
        if (trk_err) err_n = 1'b1;
        // Reversal capture first, so a same-cycle final capture lands after it.
        if (trk_cap) begin
          if (ncap_n == NCW'(DIGITS)) err_n = 1'b1;
          else begin
            for (int unsigned i = 0; i < DIGITS; i++)
              if (NCW'(i) == ncap_n) digits_n[i] = trk_digit;
            ncap_n = ncap_n + 1'b1;
          end
        end
        if (try_edge) begin
          if (ncap_n == NCW'(DIGITS)) err_n = 1'b1;
          else begin
            for (int unsigned i = 0; i < DIGITS; i++)
              if (NCW'(i) == ncap_n) digits_n[i] = trk_pos;
            ncap_n = ncap_n + 1'b1;
          end
          state_n = S_CHECK;
        end else if (trk_step) begin
          tmr_n = TW'(ENTRY_TO_CYC - 1);
        end else if (tmr_q == '0) begin
          state_n = S_IDLE;
        end else begin
          tmr_n = tmr_q - 1'b1;
        end
      end
      S_CHECK: begin
        if (ncap_q == NCW'(DIGITS) && !err_q && digits_q == code) begin
          state_n = S_OPEN;
          fail_n  = '0;
          tmr_n   = TW'(OPEN_CYC - 1);
`ifdef SAFE_PROGRESSIVE_LOCKOUT_EN
          lvl_n   = '0;
`endif
        end else begin
          state_n = S_FAIL;
        end
      end
      S_OPEN: begin
        if (try_edge)            tmr_n   = TW'(OPEN_CYC - 1);
        else if (tmr_q == '0)    state_n = S_IDLE;
        else                     tmr_n   = tmr_q - 1'b1;
      end
      S_FAIL: begin
        fail_n = (fail_q == 2'(MAX_FAIL)) ? fail_q : fail_q + 2'd1;
        if (fail_n == 2'(MAX_FAIL)) begin
          state_n = S_LOCKOUT;
          tmr_n   = lock_dur - 1'b1;
`ifdef SAFE_PROGRESSIVE_LOCKOUT_EN
          lvl_n   = (lvl_q == 2'd3) ? lvl_q : lvl_q + 2'd1;
`endif
        end else begin
          state_n = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (tmr_q == '0) begin
          state_n = S_IDLE;
          fail_n  = '0;
        end else begin
          tmr_n = tmr_q - 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      try_q      <= 1'b0;
      digits_q   <= '0;
      ncap_q     <= '0;
      err_q      <= 1'b0;
      tmr_q      <= '0;
      fail_q     <= '0;
      lock_open  <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state_q    <= state_n;
      try_q      <= tryopen;
      digits_q   <= digits_n;
      ncap_q     <= ncap_n;
      err_q      <= err_n;
      tmr_q      <= tmr_n;
      fail_q     <= fail_n;
      lock_open  <= (state_n == S_OPEN);
      locked_out <= (state_n == S_LOCKOUT);
    end
  end

`ifdef SAFE_PROGRESSIVE_LOCKOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lvl_q <= '0;
    else     lvl_q <= lvl_n;
  end
`endif

endmodule

// File: doc/safe_access_ctrl.md
Name: safe_access_ctrl

Overview:
- Access sequencer for the strong-box lock.
- Decodes the 10-position one-hot dial (`keypad`) into a combination by capturing a digit at every direction reversal.
- Compares the captured combination against the stored 6-digit code on a `tryopen` edge, then drives the lock.
- Also owns open-hold timing, failure counting and penalty lockout; sits between the keypad/tryopen inputs and the lock actuator.

Parameters:
- DIGITS, 6: combination length (4-bit BCD digits).
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout.
- OPEN_CYC, 500: cycles `lock_open` stays high after a match.
- LOCKOUT_CYC, 1000: base lockout duration in cycles.
- ENTRY_TO_CYC, 2000: idle-entry timeout (cycles without a dial step).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- code  in  4*DIGITS  stored combination; digit 0 (first entered) in [3:0].
- keypad  in  10  one-hot dial position; bit n = digit n.
- tryopen  in  1  level input; only rising edges act.
- lock_open  out  1  lock actuator, high = open.
- locked_out  out  1  penalty lockout active.
- fail_cnt  out  2  consecutive failures, saturates at MAX_FAIL.
- state_o  out  3  current FSM state for status display.

Behaviour:
- Reset values: `lock_open`=0, `locked_out`=0, `fail_cnt`=0, FSM=IDLE, digit buffer cleared, timers 0.
- `tryopen` is edge-detected with a registered previous value; a level held high never retriggers.
- Dial sampling:
  - A sample is valid only if exactly one `keypad` bit is set; other samples are ignored (position held).
  - Step +1 means new == (prev+1) mod 10 (9→0 wraps); step -1 means new == (prev-1) mod 10.
  - Unchanged position = no step.
  - Any other change sets the `err` flag; the new position is adopted with direction = none.
- FSM states: IDLE, ENTRY, CHECK, OPEN, FAIL, LOCKOUT.
- IDLE:
  - `tryopen` edge → ENTRY.
  - Entry clears the buffer, `ncap`=0, `err`=0, direction=none; the current valid position is the start position.
- ENTRY:
  - First step only sets direction.
  - A step opposite to the current direction captures the previous position into `buf[ncap]` and increments `ncap`.
  - A capture when `ncap`==DIGITS sets `err`; `ncap` saturates.
  - `tryopen` edge captures the current position as the final digit, same saturation rule → CHECK.
  - ENTRY_TO_CYC cycles without a step → IDLE, no failure counted.
- CHECK (exactly 1 cycle):
  - Match = `ncap`==DIGITS && !`err` && buf==code.
  - Match → OPEN, `fail_cnt`←0.
  - No match → FAIL.
- OPEN:
  - `lock_open`=1 for OPEN_CYC cycles, then → IDLE.
  - A `tryopen` edge during OPEN restarts the hold timer.
- FAIL (1 cycle):
  - `fail_cnt`++.
  - If the new value == MAX_FAIL → LOCKOUT; else → IDLE.
- LOCKOUT:
  - `locked_out`=1 for the lockout duration; `tryopen` is ignored.
  - On exit, `fail_cnt`←0 → IDLE.
- Timing:
  - Latency from the `tryopen` edge (the cycle the edge is first sampled) to `lock_open`=1 is 2 cycles.
  - `lock_open` and `locked_out` are registered and never high together.
- Simultaneous `tryopen` edge and dial step in ENTRY: the step is processed first, then the final capture uses the new position.
- Reset mid-operation: immediate return to reset values, including an active OPEN (lock closes asynchronously).

Optional Feature:
- Macro: SAFE_PROGRESSIVE_LOCKOUT_EN.
- Defined:
  - A 2-bit `lock_level` counter increments on each LOCKOUT entry (saturates at 3).
  - Lockout duration = LOCKOUT_CYC << `lock_level` (prior level).
  - `lock_level` clears only on a successful OPEN or on reset.
- Undefined: every lockout lasts LOCKOUT_CYC; no `lock_level` register exists.

Decomposition:
- Package `safe_pkg`:
  - FSM state enum.
  - Digit width constant (4).
  - One-hot-to-BCD decode function.
  - `mod10_inc`/`mod10_dec` helpers.
- Sub-module `dial_tracker`:
  - One-hot validation and position register.
  - Step/direction detection.
  - Emits a capture strobe with the captured digit, plus an error strobe.
  - `safe_access_ctrl` owns the FSM, buffer, timers and counters.

Test Plan:
1. Code 172839; `tryopen` pulse, dial 7→8→9→0→1→0→9→8→7→8→9→0→1→2→1→0→9→8→9→0→1→2→3→2→1→0→9, `tryopen` edge → captures 1,7,2,8,3,9; `lock_open`=1 2 cycles after the edge, for 500 cycles; `fail_cnt`=0.
2. Same sequence with final digit 8 → FAIL; `fail_cnt`=1; `lock_open` stays 0; state returns to IDLE.
3. Three consecutive wrong entries → `locked_out`=1 for 1000 cycles; `tryopen` during lockout ignored; then `fail_cnt`=0.
4. Dial jump 7→3 mid-entry, otherwise correct → `err` set → failure counted; invalid two-hot sample ignored with no error.
5. Enter ENTRY, no dial steps for 2000 cycles → IDLE, `fail_cnt` unchanged; assert `rst` during OPEN → `lock_open` drops immediately.
6. With SAFE_PROGRESSIVE_LOCKOUT_EN defined: second lockout lasts 2000 cycles, third 4000; a correct entry then clears the level.
